// File: rtl/gate_lane_arbiter.sv
// gate_lane_arbiter: shares one parking gate between the entry and exit lanes.
// Round-robin grant between eligible lanes, gate open/close sequencing,
// occupancy tracking with full/empty flags and a sticky passage-timeout alarm.
// Every output is a register; the combinational block below only computes
// the values those registers take on the next clock edge.
`timescale 1ns/1ps

module gate_lane_arbiter #(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = 5,
    parameter int TIMEOUT  = 255,
    parameter int TMR_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             pass_done,
    input  logic             blocked,
    input  logic             clr_alm,
    output logic             gnt_in,
    output logic             gnt_out,
    output logic             gate_o,
    output logic             gate_cls,
    output logic             alm_timeout,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2,
        ALARM   = 2'd3
    } state_t;

    typedef enum logic {
        DIR_EXIT  = 1'b0,
        DIR_ENTRY = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    dir_t               dir, dir_nxt;
    dir_t               last_dir, last_dir_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [CNT_W-1:0]   occ_nxt;
    logic               gnt_in_nxt, gnt_out_nxt;
    logic               gate_o_nxt, gate_cls_nxt;
    logic               alm_nxt;
    logic               full_nxt, empty_nxt;
    logic               ent_ok, ext_ok;

    // A lane is only eligible when serving it cannot overflow or underflow the lot.
    assign ent_ok = req_in  & ~full;
    assign ext_ok = req_out & ~empty;

    // Next-state, next-output and bookkeeping logic for the gate FSM.
    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        last_dir_nxt = last_dir;
        timer_nxt    = timer;
        occ_nxt      = occupancy;
        gnt_in_nxt   = 1'b0;
        gnt_out_nxt  = 1'b0;
        gate_o_nxt   = 1'b0;
        gate_cls_nxt = 1'b0;
        alm_nxt      = alm_timeout;

        case (state)
            IDLE: begin
                // Entry wins when it is the only eligible lane or when exit was served last.
                if (ent_ok && (!ext_ok || last_dir == DIR_EXIT)) begin
                    state_nxt    = OPEN;
                    gnt_in_nxt   = 1'b1;
                    gate_o_nxt   = 1'b1;
                    dir_nxt      = DIR_ENTRY;
                    last_dir_nxt = DIR_ENTRY;
                    timer_nxt    = '0;
                end else if (ext_ok) begin
                    state_nxt    = OPEN;
                    gnt_out_nxt  = 1'b1;
                    gate_o_nxt   = 1'b1;
                    dir_nxt      = DIR_EXIT;
                    last_dir_nxt = DIR_EXIT;
                    timer_nxt    = '0;
                end
            end

            OPEN: begin
                gate_o_nxt = 1'b1;
                if (blocked) begin
                    // Obstruction: hold everything, a simultaneous pass_done is discarded.
                    state_nxt = OPEN;
                end else if (pass_done) begin
                    state_nxt    = CLOSING;
                    gate_o_nxt   = 1'b0;
                    gate_cls_nxt = 1'b1;
                    if (dir == DIR_ENTRY) begin
                        if (occupancy != CAP_V) occ_nxt = occupancy + CNT_W'(1);
                    end else begin
                        if (occupancy != '0)    occ_nxt = occupancy - CNT_W'(1);
                    end
                end else if (timer == TMO_LAST) begin
                    state_nxt  = ALARM;
                    gate_o_nxt = 1'b0;
                    alm_nxt    = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            CLOSING: begin
                state_nxt = IDLE;
            end

            ALARM: begin
                alm_nxt = 1'b1;
                if (clr_alm) begin
                    state_nxt = IDLE;
                    alm_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        full_nxt  = (occ_nxt == CAP_V);
        empty_nxt = (occ_nxt == '0);
    end

    // State, bookkeeping and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dir         <= DIR_EXIT;
            last_dir    <= DIR_EXIT;
            timer       <= '0;
            occupancy   <= '0;
            gnt_in      <= 1'b0;
            gnt_out     <= 1'b0;
            gate_o      <= 1'b0;
            gate_cls    <= 1'b0;
            alm_timeout <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            last_dir    <= last_dir_nxt;
            timer       <= timer_nxt;
            occupancy   <= occ_nxt;
            gnt_in      <= gnt_in_nxt;
            gnt_out     <= gnt_out_nxt;
            gate_o      <= gate_o_nxt;
            gate_cls    <= gate_cls_nxt;
            alm_timeout <= alm_nxt;
            full        <= full_nxt;
            empty       <= empty_nxt;
        end
    end

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// tb_gate_lane_arbiter: directed scenarios for gate_lane_arbiter with a
// scoreboard of expected output events and a monitor that pops and compares.
`timescale 1ns/1ps

module tb_gate_lane_arbiter;

    localparam int CAP   = 4;
    localparam int CNT_W = 3;
    localparam int TMO   = 8;
    localparam int TMR_W = 4;

    // {gnt_in, gnt_out, gate_o, gate_cls, alm_timeout, occupancy[2:0], full, empty}
    typedef logic [9:0] rec_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_in, req_out, pass_done, blocked, clr_alm;
    logic             gnt_in, gnt_out, gate_o, gate_cls, alm_timeout;
    logic [CNT_W-1:0] occupancy;
    logic             full, empty;

    int   n_total = 0;
    int   n_pass  = 0;
    rec_t exp_q[$];
    int   occ_m   = 0;
    logic dir_m   = 1'b0;

    gate_lane_arbiter #(
        .CAPACITY(CAP),
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO),
        .TMR_W   (TMR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_in     (req_in),
        .req_out    (req_out),
        .pass_done  (pass_done),
        .blocked    (blocked),
        .clr_alm    (clr_alm),
        .gnt_in     (gnt_in),
        .gnt_out    (gnt_out),
        .gate_o     (gate_o),
        .gate_cls   (gate_cls),
        .alm_timeout(alm_timeout),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    function automatic rec_t mk(input logic gi, input logic go, input logic gate,
                                input logic cls, input logic alm, input int occ);
        logic [2:0] o;
        o = occ[2:0];
        return {gi, go, gate, cls, alm, o, (occ == CAP), (occ == 0)};
    endfunction

    function automatic rec_t obs();
        return {gnt_in, gnt_out, gate_o, gate_cls, alm_timeout, occupancy, full, empty};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asserts reset away from any clock edge and checks outputs before the next edge.
    task automatic do_reset();
        reset = 1'b1;
        req_in = 1'b0; req_out = 1'b0; pass_done = 1'b0; blocked = 1'b0; clr_alm = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        occ_m = 0;
        dir_m = 1'b0;
    endtask

    task automatic request(input logic ri, input logic ro, input logic entry);
        req_in  = ri;
        req_out = ro;
        exp_q.push_back(mk(entry, !entry, 1, 0, 0, occ_m));
        tick();
        if (entry) req_in = 1'b0;
        else       req_out = 1'b0;
        dir_m = entry;
    endtask

    task automatic pass();
        pass_done = 1'b1;
        if (dir_m) occ_m++;
        else       occ_m--;
        exp_q.push_back(mk(0, 0, 0, 1, 0, occ_m));
        tick();
        pass_done = 1'b0;
        tick();
    endtask

    // Monitor: every grant, close pulse or alarm change must match the oldest expectation.
    initial begin
        logic alm_prev;
        rec_t e;
        alm_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0) begin
                alm_prev = alm_timeout;
                continue;
            end
            chk("exclusive_outputs", {30'd0, gnt_in & gnt_out, gate_o & gate_cls}, 32'd0);
            if (gnt_in || gnt_out || gate_cls || (alm_timeout != alm_prev)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(obs()), 32'h3ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_event", 32'(obs()), 32'(e));
                end
            end
            alm_prev = alm_timeout;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        req_in = 1'b0; req_out = 1'b0; pass_done = 1'b0; blocked = 1'b0; clr_alm = 1'b0;
        #2;
        do_reset();

        // T1: single entry, gate opens then closes, occupancy 1.
        request(1, 0, 1);
        pass();
        chk("t1_empty_after_entry", 32'(empty), 32'd0);

        // Bring the lot to occupancy 3 with exit served last.
        request(1, 0, 1); pass();
        request(1, 0, 1); pass();
        request(1, 0, 1); pass();
        request(0, 1, 0); pass();
        chk("setup_occ3", 32'(occupancy), 32'd3);

        // T2: simultaneous requests alternate entry / exit / entry.
        request(1, 1, 1); pass();
        request(0, 1, 0); pass();
        request(1, 1, 1);
        req_out = 1'b0;
        pass();
        chk("t2_full", 32'(full), 32'd1);

        // T3: full lot refuses entry, exit still served.
        req_in = 1'b1;
        repeat (20) tick();
        chk("t3_gate_closed_when_full", 32'(gate_o), 32'd0);
        request(1, 1, 0);
        req_in = 1'b0;
        pass();
        chk("t3_not_full_after_exit", 32'(full), 32'd0);

        // T4: empty lot refuses exit.
        do_reset();
        req_out = 1'b1;
        repeat (20) tick();
        chk("t4_empty_gate", 32'({empty, gate_o}), 32'b10);
        req_out = 1'b0;

        // T5: passage timeout, requests ignored in alarm, clear and re-grant.
        request(1, 0, 1);
        repeat (TMO - 1) tick();
        chk("t5_no_alarm_yet", 32'({alm_timeout, gate_o}), 32'b01);
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
        tick();
        req_in = 1'b1;
        repeat (10) tick();
        chk("t5_alarm_held", 32'({alm_timeout, gate_o}), 32'b10);
        clr_alm = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        tick();
        clr_alm = 1'b0;
        exp_q.push_back(mk(1, 0, 1, 0, 0, 0));
        tick();
        req_in = 1'b0;
        dir_m = 1'b1;
        pass();

        // T6: blocked freezes timer and discards pass_done.
        request(1, 0, 1);
        blocked = 1'b1;
        for (int i = 0; i < 50; i++) begin
            pass_done = (i == 10 || i == 30);
            tick();
        end
        pass_done = 1'b0;
        chk("t6_still_open", 32'({alm_timeout, gate_o, occupancy}), 32'({1'b0, 1'b1, 3'd1}));
        blocked = 1'b0;
        pass();

        // Timer resumes from its frozen value after the obstruction.
        request(1, 0, 1);
        repeat (3) tick();
        blocked = 1'b1;
        repeat (20) tick();
        blocked = 1'b0;
        repeat (4) tick();
        chk("t6_frozen_timer_no_alarm", 32'({alm_timeout, gate_o}), 32'b01);
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2));
        tick();
        clr_alm = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2));
        tick();
        clr_alm = 1'b0;

        // Reset mid-OPEN takes effect without a clock edge.
        request(1, 0, 1);
        tick();
        chk("t6_open_before_reset", 32'(gate_o), 32'd1);
        #2;
        do_reset();
        request(1, 0, 1);
        pass();

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
